// File: rtl/dm_pkg.sv
// Shared definitions for the debug module: register map, field positions,
// abstract command layout, cmderr codes and FSM encodings.
package dm_pkg;

    localparam logic [6:0] ADDR_DATA0      = 7'h04;
    localparam logic [6:0] ADDR_DMCONTROL  = 7'h10;
    localparam logic [6:0] ADDR_DMSTATUS   = 7'h11;
    localparam logic [6:0] ADDR_ABSTRACTCS = 7'h16;
    localparam logic [6:0] ADDR_COMMAND    = 7'h17;

    localparam int DMC_HALTREQ   = 31;
    localparam int DMC_RESUMEREQ = 30;
    localparam int DMC_NDMRESET  = 1;
    localparam int DMC_DMACTIVE  = 0;

    localparam int DMS_ALLRESUMEACK  = 17;
    localparam int DMS_ANYRESUMEACK  = 16;
    localparam int DMS_ALLRUNNING    = 11;
    localparam int DMS_ANYRUNNING    = 10;
    localparam int DMS_ALLHALTED     = 9;
    localparam int DMS_ANYHALTED     = 8;
    localparam int DMS_AUTHENTICATED = 7;

    localparam int ACS_BUSY       = 12;
    localparam int ACS_CMDERR_MSB = 10;
    localparam int ACS_CMDERR_LSB = 8;
    localparam logic [3:0] ACS_DATACOUNT = 4'd1;

    localparam logic [2:0]  AARSIZE_32     = 3'd2;
    localparam logic [15:0] REGNO_GPR_BASE = 16'h1000;

    localparam logic [2:0] CMDERR_NONE       = 3'd0;
    localparam logic [2:0] CMDERR_BUSY       = 3'd1;
    localparam logic [2:0] CMDERR_NOTSUP     = 3'd2;
    localparam logic [2:0] CMDERR_HALTRESUME = 3'd4;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_REQ  = 1'b1;

    localparam logic [1:0] A_IDLE = 2'd0;
    localparam logic [1:0] A_REQ  = 2'd1;
    localparam logic [1:0] A_DONE = 2'd2;

    typedef struct packed {
        logic [7:0]  cmdtype;
        logic        rsvd;
        logic [2:0]  aarsize;
        logic        postinc;
        logic        postexec;
        logic        transfer;
        logic        write;
        logic [15:0] regno;
    } abs_cmd_t;

endpackage

// File: rtl/dm_abscmd.sv
// Abstract command engine: decodes access-register commands, owns data0 and
// cmderr, and runs the GPR request/ack handshake with the hart.
module dm_abscmd
    import dm_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        halted_i,
    input  logic        wr_data0_i,
    input  logic        wr_abscs_i,
    input  logic        wr_cmd_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] data0_o,
    output logic [2:0]  cmderr_o,
    output logic        busy_o,
    output logic        reg_req_o,
    output logic        reg_we_o,
    output logic [4:0]  reg_addr_o,
    output logic [31:0] reg_wdata_o,
    input  logic [31:0] reg_rdata_i,
    input  logic        reg_ack_i
);

    logic [1:0]  state_q, state_d;
    logic [31:0] data0_q, data0_d;
    logic [2:0]  cmderr_q, cmderr_d;
    logic        orphan_q, orphan_d;
    logic        we_q, we_d;
    logic [4:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    abs_cmd_t    cmd;
    logic        cmd_ok;
    logic        busy;
    logic        unused_cmd;

    assign cmd        = abs_cmd_t'(wdata_i);
    assign cmd_ok     = (cmd.cmdtype == 8'd0) && (cmd.aarsize == AARSIZE_32) &&
                        (cmd.regno[15:5] == REGNO_GPR_BASE[15:5]);
    assign busy       = (state_q != A_IDLE);
    assign unused_cmd = cmd.rsvd ^ cmd.postinc ^ cmd.postexec;

    always_comb begin
        state_d  = state_q;
        data0_d  = data0_q;
        cmderr_d = cmderr_q;
        orphan_d = orphan_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        if (clear_i) begin
            // A request in flight cannot be withdrawn; keep it up until the
            // hart acks, then throw the result away.
            state_d  = A_IDLE;
            data0_d  = '0;
            cmderr_d = CMDERR_NONE;
            orphan_d = (orphan_q || state_q == A_REQ) && !reg_ack_i;
        end else begin
            if (orphan_q && reg_ack_i)
                orphan_d = 1'b0;
            case (state_q)
                A_REQ: if (reg_ack_i) begin
                    state_d = A_DONE;
                    if (!we_q)
                        data0_d = reg_rdata_i;
                end
                A_DONE:  state_d = A_IDLE;
                default: ;
            endcase
            if (busy && (wr_data0_i || wr_abscs_i || wr_cmd_i)) begin
                if (cmderr_q == CMDERR_NONE)
                    cmderr_d = CMDERR_BUSY;
            end else if (wr_data0_i) begin
                data0_d = wdata_i;
            end else if (wr_abscs_i) begin
                cmderr_d = cmderr_q & ~wdata_i[ACS_CMDERR_MSB:ACS_CMDERR_LSB];
            end else if (wr_cmd_i && cmderr_q == CMDERR_NONE && !orphan_q) begin
                if (!cmd_ok)
                    cmderr_d = CMDERR_NOTSUP;
                else if (cmd.transfer) begin
                    if (!halted_i)
                        cmderr_d = CMDERR_HALTRESUME;
                    else begin
                        state_d = A_REQ;
                        we_d    = cmd.write;
                        addr_d  = cmd.regno[4:0];
                        wdata_d = data0_q;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= A_IDLE;
            data0_q  <= '0;
            cmderr_q <= CMDERR_NONE;
            orphan_q <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            data0_q  <= data0_d;
            cmderr_q <= cmderr_d;
            orphan_q <= orphan_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign data0_o     = data0_q;
    assign cmderr_o    = cmderr_q;
    assign busy_o      = busy;
    assign reg_req_o   = (state_q == A_REQ) || orphan_q;
    assign reg_we_o    = we_q;
    assign reg_addr_o  = addr_q;
    assign reg_wdata_o = wdata_q;

endmodule

// File: rtl/dm_ctrl.sv
// RISC-V debug module control: DMI Wishbone slave, dmcontrol/dmstatus,
// halt request and resume handshake for a single hart.
module dm_ctrl
    import dm_pkg::*;
#(
    parameter int unsigned DMI_ADDRW  = 9,
    parameter int unsigned DMI_DATAW  = 32,
    parameter logic [3:0]  DM_VERSION = 4'd2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DMI_ADDRW-1:0] dmi_wb_adr_i,
    input  logic [DMI_DATAW-1:0] dmi_wb_dat_i,
    output logic [DMI_DATAW-1:0] dmi_wb_dat_o,
    input  logic                 dmi_wb_cyc_i,
    input  logic                 dmi_wb_stb_i,
    input  logic                 dmi_wb_we_i,
    input  logic [3:0]           dmi_wb_sel_i,
    output logic                 dmi_wb_ack_o,
    output logic                 dmactive_o,
    output logic                 ndmreset_o,
    output logic                 hart_haltreq_o,
    output logic                 hart_resumereq_o,
    input  logic                 hart_resumeack_i,
    input  logic                 hart_halted_i,
    output logic                 hart_reg_req_o,
    output logic                 hart_reg_we_o,
    output logic [4:0]           hart_reg_addr_o,
    output logic [31:0]          hart_reg_wdata_o,
    input  logic [31:0]          hart_reg_rdata_i,
    input  logic                 hart_reg_ack_i
);

    logic                 ack_q, ack_d;
    logic [DMI_DATAW-1:0] rdata_q, rdata_d;
    logic                 dmactive_q, dmactive_d;
    logic                 haltreq_q, haltreq_d;
    logic                 ndmreset_q, ndmreset_d;
    logic [0:0]           r_state_q, r_state_d;
    logic                 resumeack_q, resumeack_d;
    logic                 access, wr, wr_dmc, clear;
    logic                 sel_data0, sel_dmc, sel_dms, sel_acs, sel_cmd;
    logic [31:0]          data0;
    logic [2:0]           cmderr;
    logic                 busy;
    logic                 unused_sel;

    assign access     = dmi_wb_cyc_i & dmi_wb_stb_i & ~ack_q;
    assign wr         = access & dmi_wb_we_i;
    assign sel_data0  = (dmi_wb_adr_i == DMI_ADDRW'(ADDR_DATA0));
    assign sel_dmc    = (dmi_wb_adr_i == DMI_ADDRW'(ADDR_DMCONTROL));
    assign sel_dms    = (dmi_wb_adr_i == DMI_ADDRW'(ADDR_DMSTATUS));
    assign sel_acs    = (dmi_wb_adr_i == DMI_ADDRW'(ADDR_ABSTRACTCS));
    assign sel_cmd    = (dmi_wb_adr_i == DMI_ADDRW'(ADDR_COMMAND));
    assign wr_dmc     = wr & sel_dmc;
    assign unused_sel = ^dmi_wb_sel_i;
    // Everything but dmactive sits in reset while inactive, and a write that
    // drops dmactive clears state on that same edge.
    assign clear      = ~dmactive_q | (wr_dmc & ~dmi_wb_dat_i[DMC_DMACTIVE]);

    always_comb begin
        ack_d   = access;
        rdata_d = rdata_q;
        if (access) begin
            rdata_d = '0;
            if (sel_data0) begin
                rdata_d = data0;
            end else if (sel_dmc) begin
                rdata_d[DMC_HALTREQ]  = haltreq_q;
                rdata_d[DMC_NDMRESET] = ndmreset_q;
                rdata_d[DMC_DMACTIVE] = dmactive_q;
            end else if (sel_dms) begin
                rdata_d[DMS_ALLRESUMEACK]  = resumeack_q;
                rdata_d[DMS_ANYRESUMEACK]  = resumeack_q;
                rdata_d[DMS_ALLRUNNING]    = ~hart_halted_i;
                rdata_d[DMS_ANYRUNNING]    = ~hart_halted_i;
                rdata_d[DMS_ALLHALTED]     = hart_halted_i;
                rdata_d[DMS_ANYHALTED]     = hart_halted_i;
                rdata_d[DMS_AUTHENTICATED] = 1'b1;
                rdata_d[3:0]               = DM_VERSION;
            end else if (sel_acs) begin
                rdata_d[ACS_BUSY]                      = busy;
                rdata_d[ACS_CMDERR_MSB:ACS_CMDERR_LSB] = cmderr;
                rdata_d[3:0]                           = ACS_DATACOUNT;
            end
        end
    end

    always_comb begin
        dmactive_d  = wr_dmc ? dmi_wb_dat_i[DMC_DMACTIVE] : dmactive_q;
        haltreq_d   = haltreq_q;
        ndmreset_d  = ndmreset_q;
        r_state_d   = r_state_q;
        resumeack_d = resumeack_q;
        if (clear) begin
            haltreq_d   = 1'b0;
            ndmreset_d  = 1'b0;
            r_state_d   = R_IDLE;
            resumeack_d = 1'b0;
        end else begin
            if (wr_dmc) begin
                haltreq_d  = dmi_wb_dat_i[DMC_HALTREQ];
                ndmreset_d = dmi_wb_dat_i[DMC_NDMRESET];
            end
            if (r_state_q == R_IDLE) begin
                if (wr_dmc && dmi_wb_dat_i[DMC_RESUMEREQ] && !dmi_wb_dat_i[DMC_HALTREQ]) begin
                    r_state_d   = R_REQ;
                    resumeack_d = 1'b0;
                end
            end else if (hart_resumeack_i) begin
                r_state_d   = R_IDLE;
                resumeack_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q       <= 1'b0;
            rdata_q     <= '0;
            dmactive_q  <= 1'b0;
            haltreq_q   <= 1'b0;
            ndmreset_q  <= 1'b0;
            r_state_q   <= R_IDLE;
            resumeack_q <= 1'b0;
        end else begin
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            dmactive_q  <= dmactive_d;
            haltreq_q   <= haltreq_d;
            ndmreset_q  <= ndmreset_d;
            r_state_q   <= r_state_d;
            resumeack_q <= resumeack_d;
        end
    end

    dm_abscmd u_abscmd (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (clear),
        .halted_i    (hart_halted_i),
        .wr_data0_i  (wr & sel_data0),
        .wr_abscs_i  (wr & sel_acs),
        .wr_cmd_i    (wr & sel_cmd),
        .wdata_i     (dmi_wb_dat_i[31:0]),
        .data0_o     (data0),
        .cmderr_o    (cmderr),
        .busy_o      (busy),
        .reg_req_o   (hart_reg_req_o),
        .reg_we_o    (hart_reg_we_o),
        .reg_addr_o  (hart_reg_addr_o),
        .reg_wdata_o (hart_reg_wdata_o),
        .reg_rdata_i (hart_reg_rdata_i),
        .reg_ack_i   (hart_reg_ack_i)
    );

    assign dmi_wb_ack_o     = ack_q;
    assign dmi_wb_dat_o     = rdata_q;
    assign dmactive_o       = dmactive_q;
    assign ndmreset_o       = ndmreset_q & dmactive_q;
    assign hart_haltreq_o   = haltreq_q & dmactive_q;
    assign hart_resumereq_o = (r_state_q == R_REQ);

endmodule
